// File: rtl/bound_flasher_prog.sv
// Programmable thermometer lamp bar: ramps the level through a run-time loaded
// table of target levels, with per-stage kickback driven by flick.
//
// state | meaning
// IDLE  | level held, table writable, waiting for flick with seq_len != 0
// RUN   | stepping toward the current stage target once per prescaler tick
module bound_flasher_prog #(
  parameter int WIDTH      = 16,
  parameter int NUM_STAGES = 8,
  parameter int DIV        = 1,
  localparam int LW = $clog2(WIDTH + 1),
  localparam int SW = $clog2(NUM_STAGES),
  localparam int QW = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flick,
  input  logic [QW-1:0]    seq_len,
  input  logic             cfg_we,
  input  logic [SW-1:0]    cfg_addr,
  input  logic [LW-1:0]    cfg_target,
  input  logic             cfg_kb_en,
  input  logic [SW-1:0]    cfg_kb_stage,
  output logic [WIDTH-1:0] lamp,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage_idx,
  output logic             cfg_err
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(DIV - 1);
  localparam logic [LW-1:0] LVL_MAX  = LW'(WIDTH);
  localparam logic [SW-1:0] STG_MAX  = SW'(NUM_STAGES - 1);
  localparam logic [QW-1:0] LEN_MAX  = QW'(NUM_STAGES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [QW-1:0] len_q, len_d;
  logic [PW-1:0] psc_q, psc_d;
  logic          done_d;

  logic [LW-1:0] tgt_mem      [NUM_STAGES];
  logic          kb_en_mem    [NUM_STAGES];
  logic [SW-1:0] kb_stage_mem [NUM_STAGES];

  logic          cfg_ok;
  logic          tick;
  logic [LW-1:0] cur_tgt;

  // Zero-extended compares keep the range checks meaningful for any NUM_STAGES.
  assign cfg_ok  = cfg_we && (state_q == IDLE) &&
                   ({1'b0, cfg_addr} < (SW+1)'(NUM_STAGES));
  assign tick    = (psc_q == PSC_LAST);
  assign cur_tgt = tgt_mem[stage_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        tgt_mem[i]      <= '0;
        kb_en_mem[i]    <= 1'b0;
        kb_stage_mem[i] <= '0;
      end
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        tgt_mem[cfg_addr]      <= (cfg_target > LVL_MAX) ? LVL_MAX : cfg_target;
        kb_en_mem[cfg_addr]    <= cfg_kb_en;
        kb_stage_mem[cfg_addr] <= ({1'b0, cfg_kb_stage} > (SW+1)'(NUM_STAGES - 1)) ?
                                  STG_MAX : cfg_kb_stage;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      level_q <= '0;
      stage_q <= '0;
      len_q   <= '0;
      psc_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      stage_q <= stage_d;
      len_q   <= len_d;
      psc_q   <= psc_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    stage_d = stage_q;
    len_d   = len_q;
    psc_d   = psc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flick && (seq_len != '0)) begin
          state_d = RUN;
          stage_d = '0;
          psc_d   = '0;
          len_d   = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
        end
      end
      RUN: begin
        if (!tick) begin
          psc_d = psc_q + 1'b1;
        end else begin
          psc_d = '0;
          if (level_q < cur_tgt) begin
            level_d = level_q + 1'b1;
          end else if (level_q > cur_tgt) begin
            level_d = level_q - 1'b1;
          end else if (kb_en_mem[stage_q] && flick) begin
            stage_d = kb_stage_mem[stage_q];
          // A kickback landing past the active length ends the run at that stage.
          end else if (QW'(stage_q) >= (len_q - 1'b1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lamp = '0;
    for (int i = 0; i < WIDTH; i++) lamp[i] = (level_q > LW'(i));
  end

  assign busy      = (state_q == RUN);
  assign stage_idx = stage_q;

endmodule

// File: tb/tb_bound_flasher_prog.sv
// Directed bench for bound_flasher_prog: dut_a uses defaults (16 lamps, 8 stages,
// DIV=1); dut_b uses 5 stages and DIV=4 for prescaler and address range cases.
module tb_bound_flasher_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_flick = 1'b0, a_cfg_we = 1'b0;
  logic [3:0]  a_seq_len = '0;
  logic        b_flick = 1'b0, b_cfg_we = 1'b0;
  logic [2:0]  b_seq_len = '0;
  logic [2:0]  cfg_addr = '0;
  logic [4:0]  cfg_target = '0;
  logic        cfg_kb_en = 1'b0;
  logic [2:0]  cfg_kb_stage = '0;

  logic [15:0] a_lamp, b_lamp;
  logic        a_busy, a_done, a_cfg_err, b_busy, b_done, b_cfg_err;
  logic [2:0]  a_stage, b_stage;

  int n_checks = 0;
  int n_pass   = 0;

  bound_flasher_prog #(.WIDTH(16), .NUM_STAGES(8), .DIV(1)) dut_a (
    .clk(clk), .rst(rst), .flick(a_flick), .seq_len(a_seq_len),
    .cfg_we(a_cfg_we), .cfg_addr(cfg_addr), .cfg_target(cfg_target),
    .cfg_kb_en(cfg_kb_en), .cfg_kb_stage(cfg_kb_stage),
    .lamp(a_lamp), .busy(a_busy), .done(a_done), .stage_idx(a_stage), .cfg_err(a_cfg_err));

  bound_flasher_prog #(.WIDTH(16), .NUM_STAGES(5), .DIV(4)) dut_b (
    .clk(clk), .rst(rst), .flick(b_flick), .seq_len(b_seq_len),
    .cfg_we(b_cfg_we), .cfg_addr(cfg_addr), .cfg_target(cfg_target),
    .cfg_kb_en(cfg_kb_en), .cfg_kb_stage(cfg_kb_stage),
    .lamp(b_lamp), .busy(b_busy), .done(b_done), .stage_idx(b_stage), .cfg_err(b_cfg_err));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] thermo(input int l);
    logic [16:0] t;
    t = (17'd1 << l) - 17'd1;
    return t[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic cfg_wr(input bit to_b, input int addr, input int tgt, input int kb, input int kbs);
    cfg_addr     = 3'(addr);
    cfg_target   = 5'(tgt);
    cfg_kb_en    = kb[0];
    cfg_kb_stage = 3'(kbs);
    if (to_b) b_cfg_we = 1'b1; else a_cfg_we = 1'b1;
    step();
    a_cfg_we = 1'b0;
    b_cfg_we = 1'b0;
  endtask

  task automatic prog_a();
    cfg_wr(0, 0, 6, 0, 0);
    cfg_wr(0, 1, 0, 0, 0);
    cfg_wr(0, 2, 11, 1, 1);
    cfg_wr(0, 3, 5, 0, 0);
    cfg_wr(0, 4, 20, 0, 0);
    cfg_wr(0, 5, 0, 0, 0);
  endtask

  task automatic start_a(input int len);
    a_seq_len = 4'(len);
    a_flick   = 1'b1;
    step();
    a_flick   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (a_lamp !== 16'h0000) $display("FAIL reset_lamp: got %h expected 0000", a_lamp); else n_pass++;
    n_checks++; if ({a_busy, a_done, a_cfg_err} !== 3'b000) $display("FAIL reset_flags: busy/done/err got %b expected 000", {a_busy, a_done, a_cfg_err}); else n_pass++;
    n_checks++; if (a_stage !== 3'd0) $display("FAIL reset_stage: got %0d expected 0", a_stage); else n_pass++;
    n_checks++; if ({b_lamp, b_busy} !== 17'h0) $display("FAIL reset_b: lamp/busy got %h expected 0", {b_lamp, b_busy}); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_cfg_reject_busy();
    bit got_done;
    prog_a();
    start_a(6);
    repeat (10) step();
    cfg_wr(0, 0, 9, 0, 0);
    n_checks++; if (a_cfg_err !== 1'b1) $display("FAIL busy_write_err: got %b expected 1", a_cfg_err); else n_pass++;
    step();
    n_checks++; if (a_cfg_err !== 1'b0) $display("FAIL busy_write_err_pulse: got %b expected 0", a_cfg_err); else n_pass++;
    got_done = 0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      step();
      if (a_done) got_done = 1;
    end
    n_checks++; if (!got_done) $display("FAIL busy_write_run_done: got 0 expected 1"); else n_pass++;
  endtask

  task automatic test_sequence();
    int tg[6] = '{6, 0, 11, 5, 16, 0};
    int q[$];
    int lvl, lamp_err, first_bad, early_done;
    logic [15:0] bad_got, bad_exp;
    lvl = 0;
    for (int s = 0; s < 6; s++) begin
      while (lvl != tg[s]) begin
        lvl += (lvl < tg[s]) ? 1 : -1;
        q.push_back(lvl);
      end
      q.push_back(lvl);
    end
    lamp_err = 0; first_bad = -1; early_done = 0; bad_got = '0; bad_exp = '0;
    start_a(6);
    n_checks++; if (a_busy !== 1'b1) $display("FAIL seq_busy_start: got %b expected 1", a_busy); else n_pass++;
    for (int k = 0; k < 62; k++) begin
      step();
      if (a_lamp !== thermo(q[k])) begin
        if (lamp_err == 0) begin first_bad = k; bad_got = a_lamp; bad_exp = thermo(q[k]); end
        lamp_err++;
      end
      if (k < 61 && a_done) early_done++;
    end
    n_checks++; if (lamp_err != 0) $display("FAIL seq_trace: %0d errors, first tick %0d got %h expected %h", lamp_err, first_bad + 1, bad_got, bad_exp); else n_pass++;
    n_checks++; if (early_done != 0) $display("FAIL seq_early_done: got %0d expected 0", early_done); else n_pass++;
    n_checks++; if (a_done !== 1'b1) $display("FAIL seq_done_at_62: got %b expected 1", a_done); else n_pass++;
    step();
    n_checks++; if ({a_done, a_busy} !== 2'b00) $display("FAIL seq_after_done: done/busy got %b expected 00", {a_done, a_busy}); else n_pass++;
  endtask

  task automatic test_kickback();
    bit found, got_done;
    int c;
    found = 0;
    start_a(6);
    for (int i = 0; i < 100 && !found; i++) begin
      if (a_stage == 3'd2 && a_lamp == 16'h07FF) found = 1; else step();
    end
    n_checks++; if (!found) $display("FAIL kb_reach_11: got 0 expected 1"); else n_pass++;
    a_flick = 1'b1;
    step();
    n_checks++; if (a_stage !== 3'd1) $display("FAIL kb_stage: got %0d expected 1", a_stage); else n_pass++;
    n_checks++; if ({a_lamp, a_done} !== {16'h07FF, 1'b0}) $display("FAIL kb_hold: lamp/done got %h expected 0ffe", {a_lamp, a_done}); else n_pass++;
    a_flick = 1'b0;
    step();
    n_checks++; if (a_lamp !== 16'h03FF) $display("FAIL kb_ramp_down: got %h expected 03ff", a_lamp); else n_pass++;
    got_done = 0; c = 0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      step();
      c++;
      if (a_done) got_done = 1;
    end
    n_checks++; if (!got_done || c != 59) $display("FAIL kb_done_cycles: got %0d expected 59", c); else n_pass++;
  endtask

  task automatic test_div4();
    logic [15:0] lam[18];
    logic        dn[18];
    do_reset();
    cfg_wr(1, 0, 3, 0, 0);
    b_seq_len = 3'd1;
    b_flick = 1'b1;
    step();
    b_flick = 1'b0;
    for (int e = 1; e < 18; e++) begin
      step();
      lam[e] = b_lamp;
      dn[e]  = b_done;
    end
    n_checks++; if (lam[3] !== 16'h0000) $display("FAIL div4_edge3: got %h expected 0000", lam[3]); else n_pass++;
    n_checks++; if (lam[4] !== 16'h0001) $display("FAIL div4_edge4: got %h expected 0001", lam[4]); else n_pass++;
    n_checks++; if (lam[7] !== 16'h0001) $display("FAIL div4_edge7: got %h expected 0001", lam[7]); else n_pass++;
    n_checks++; if (lam[8] !== 16'h0003) $display("FAIL div4_edge8: got %h expected 0003", lam[8]); else n_pass++;
    n_checks++; if (lam[12] !== 16'h0007) $display("FAIL div4_edge12: got %h expected 0007", lam[12]); else n_pass++;
    n_checks++; if ({dn[15], dn[16], dn[17]} !== 3'b010) $display("FAIL div4_done: edges15-17 got %b expected 010", {dn[15], dn[16], dn[17]}); else n_pass++;
    n_checks++; if (b_busy !== 1'b0) $display("FAIL div4_busy_after: got %b expected 0", b_busy); else n_pass++;
  endtask

  task automatic test_cfg_range_b();
    bit moved, got_done;
    cfg_wr(1, 5, 1, 0, 0);
    n_checks++; if (b_cfg_err !== 1'b1) $display("FAIL addr_range_err: got %b expected 1", b_cfg_err); else n_pass++;
    step();
    n_checks++; if (b_cfg_err !== 1'b0) $display("FAIL addr_range_pulse: got %b expected 0", b_cfg_err); else n_pass++;
    cfg_wr(1, 0, 3, 1, 7);
    n_checks++; if (b_cfg_err !== 1'b0) $display("FAIL valid_write_err: got %b expected 0", b_cfg_err); else n_pass++;
    cfg_wr(1, 4, 0, 0, 0);
    b_seq_len = 3'd5;
    b_flick = 1'b1;
    step();
    moved = 0;
    for (int i = 0; i < 20 && !moved; i++) begin
      step();
      if (b_stage != 3'd0) moved = 1;
    end
    n_checks++; if (b_stage !== 3'd4) $display("FAIL kb_stage_clamp: got %0d expected 4", b_stage); else n_pass++;
    b_flick = 1'b0;
    got_done = 0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      step();
      if (b_done) got_done = 1;
    end
    n_checks++; if (!got_done || b_lamp !== 16'h0000) $display("FAIL kb_clamp_finish: done %b lamp %h expected 1 0000", got_done, b_lamp); else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit found;
    do_reset();
    cfg_wr(0, 0, 2, 0, 0);
    cfg_wr(0, 1, 12, 0, 0);
    start_a(2);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (a_lamp == 16'h01FF) found = 1; else step();
    end
    n_checks++; if (!found || a_stage !== 3'd1) $display("FAIL midrst_reach_9: found %b stage %0d expected 1 1", found, a_stage); else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (a_lamp !== 16'h0000) $display("FAIL midrst_lamp: got %h expected 0000", a_lamp); else n_pass++;
    n_checks++; if ({a_busy, a_done, a_stage} !== 5'b0) $display("FAIL midrst_state: busy/done/stage got %b expected 00000", {a_busy, a_done, a_stage}); else n_pass++;
    step();
    n_checks++; if (a_done !== 1'b0) $display("FAIL midrst_no_done: got %b expected 0", a_done); else n_pass++;
    start_a(1);
    n_checks++; if (a_busy !== 1'b1) $display("FAIL midrst_restart_busy: got %b expected 1", a_busy); else n_pass++;
    step();
    n_checks++; if ({a_done, a_lamp} !== {1'b1, 16'h0000}) $display("FAIL midrst_cleared_table: done/lamp got %h expected 10000", {a_done, a_lamp}); else n_pass++;
  endtask

  task automatic test_seq_len();
    bit got_done;
    int c, maxs;
    a_seq_len = 4'd0;
    a_flick = 1'b1;
    step();
    n_checks++; if (a_busy !== 1'b0) $display("FAIL seqlen0_busy: got %b expected 0", a_busy); else n_pass++;
    step();
    a_flick = 1'b0;
    n_checks++; if ({a_busy, a_cfg_err} !== 2'b00) $display("FAIL seqlen0_idle: busy/err got %b expected 00", {a_busy, a_cfg_err}); else n_pass++;
    do_reset();
    for (int i = 0; i < 8; i++) cfg_wr(0, i, (i % 2 == 0) ? 1 : 0, 0, 0);
    start_a(15);
    got_done = 0; c = 0; maxs = 0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      step();
      c++;
      if (int'(a_stage) > maxs) maxs = int'(a_stage);
      if (a_done) got_done = 1;
    end
    n_checks++; if (!got_done || c != 16) $display("FAIL seqlen15_ticks: got %0d expected 16", c); else n_pass++;
    n_checks++; if (maxs != 7) $display("FAIL seqlen15_max_stage: got %0d expected 7", maxs); else n_pass++;
  endtask

  task automatic test_level_hold();
    bit got_done;
    cfg_wr(0, 0, 4, 0, 0);
    start_a(1);
    got_done = 0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      step();
      if (a_done) got_done = 1;
    end
    n_checks++; if (!got_done || a_lamp !== 16'h000F) $display("FAIL hold_first_run: done %b lamp %h expected 1 000f", got_done, a_lamp); else n_pass++;
    cfg_wr(0, 0, 2, 0, 0);
    n_checks++; if (a_lamp !== 16'h000F) $display("FAIL hold_idle_level: got %h expected 000f", a_lamp); else n_pass++;
    start_a(1);
    step();
    n_checks++; if (a_lamp !== 16'h0007) $display("FAIL hold_restart_level: got %h expected 0007", a_lamp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cfg_reject_busy();
    test_sequence();
    test_kickback();
    test_div4();
    test_cfg_range_b();
    test_mid_reset();
    test_seq_len();
    test_level_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bound_flasher_prog.md
Name: bound_flasher_prog

Overview:
Programmable, width-generic successor of the fixed 16-lamp bound flasher. It drives a thermometer-coded lamp bar up and down through a run-time-loaded table of target levels. Per-stage kickback lets flick force a jump to another stage when that stage's bound is reached. It sits beside the existing flasher and is configured by a simple write port from the control block.

Parameters:
WIDTH, 16, number of lamps; level range 0..WIDTH
NUM_STAGES, 8, stage table depth
DIV, 1, clocks per lamp step (>=1)
LW = clog2(WIDTH+1), SW = clog2(NUM_STAGES), QW = clog2(NUM_STAGES+1): derived, not user-set

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
flick  in  1  start request in IDLE; kickback request in RUN
seq_len  in  QW  active stage count, sampled at start
cfg_we  in  1  table write strobe
cfg_addr  in  SW  table entry index
cfg_target  in  LW  target level for entry
cfg_kb_en  in  1  kickback enable for entry
cfg_kb_stage  in  SW  kickback destination stage
lamp  out  WIDTH  thermometer output: lamp = (1<<level)-1
busy  out  1  high in RUN
done  out  1  one-cycle pulse on normal sequence completion
stage_idx  out  SW  current stage
cfg_err  out  1  one-cycle pulse on rejected write

Behaviour:
- Reset (rst=1 at edge): level=0 (lamp=0), state=IDLE, busy=0, done=0, cfg_err=0, stage_idx=0, prescaler=0, all table entries {target=0, kb_en=0, kb_stage=0}. rst has priority over every other input, including mid-RUN.
- Internal level register is LW bits; lamp is decoded from it combinationally. lamp is never non-thermometer.
- Config:
  - A write is accepted only when state=IDLE and cfg_addr<NUM_STAGES. It lands at the edge.
  - cfg_target>WIDTH is stored as WIDTH.
  - cfg_kb_stage>=NUM_STAGES is stored as NUM_STAGES-1.
  - A rejected write changes nothing and pulses cfg_err for the following cycle.
- State machine:
  - IDLE:
    - flick=1 and seq_len!=0 at edge: go to RUN, stage_idx=0, prescaler=0, latch len=min(seq_len, NUM_STAGES).
    - seq_len=0: stay IDLE, no error.
    - level is held; a new run starts from the current level, not from 0.
  - RUN: tick = (prescaler==DIV-1). The prescaler wraps to 0 on tick, else increments. On each tick:
    - level<target: level+1.
    - level>target: level-1.
    - level==target (bound reached; level unchanged this tick):
      - kb_en=1 and flick=1 at this edge: stage_idx=kb_stage (kickback). The same stage may re-target itself.
      - otherwise, stage_idx==len-1: go to IDLE, done=1 next cycle.
      - otherwise: stage_idx+1.
  - Each stage therefore costs |delta|+1 ticks. A stage whose target equals the entry level consumes exactly 1 tick.
- Timing:
  - flick is sampled only at tick edges in RUN; between ticks it is ignored.
  - With DIV=1, the first level change is at the edge after the start edge.
  - With DIV=k, the first level change is k edges after the start edge.
- busy=1 exactly while in RUN. flick high in RUN has no effect other than kickback.
- Kickback loops are allowed. The block runs indefinitely while flick is held and a kickback stage keeps being reached.
- done is never asserted on kickback or on reset.

Test Plan:
1. Program 0:6, 1:0, 2:11 (kb_en, kb_stage=1), 3:5, 4:16, 5:0; seq_len=6; DIV=1; pulse flick 1 cycle.
   -> lamp 0x0001..0x003F, down to 0, up to 0x07FF, down to 0x001F, up to 0xFFFF, down to 0.
   -> done pulses once, 62 ticks after start; busy low afterwards.
2. Same program; hold flick=1 at the tick where level=11 in stage 2.
   -> stage_idx becomes 1, lamp ramps down from 0x07FF to 0, stage 2 re-runs. Release flick: sequence completes, done=1.
3. DIV=4, single entry target=3, seq_len=1, start.
   -> level changes on every 4th edge (1, 2, 3). done asserts 16 clocks after start (4 ticks).
4. Mid-RUN rst=1 at level 9.
   -> next cycle lamp=0, busy=0, stage_idx=0, no done. Table cleared: a restart with seq_len=1 finishes after 1 tick at level 0.
5. cfg_we while busy, and cfg_addr=NUM_STAGES while idle.
   -> cfg_err pulses each time, table unchanged (read back via the run in scenario 1). cfg_target=20 stored as 16.
6. seq_len=0 with flick=1.
   -> stays IDLE, busy=0. seq_len=15 with NUM_STAGES=8 -> runs exactly 8 stages.
